// File: rtl/mag_cmp_seq.sv
// mag_cmp_seq: sequential magnitude comparator that scans two WIDTH-bit
// operands CHUNK bits per cycle, most significant chunk first, and stops at
// the first chunk that differs. Results (eq/lt/gt) are registered and held
// until the deciding cycle of the next comparison.
//
// Build option: define MAG_CMP_SEQ_SIGNED_EN to add the sgn input, which
// selects two's-complement ordering by inverting the operand MSBs in the
// top chunk. Without the macro the port is absent and ordering is unsigned.
//
// WIDTH must be a multiple of CHUNK.

// One 1-bit equal/greater cell of the chunk comparison chain.
module mag_cmp_bit (
  input  logic a,
  input  logic b,
  input  logic eq_in,
  input  logic gt_in,
  output logic eq_out_c,
  output logic gt_out_c
);

  // Greater is decided by the first (most significant) differing bit.
  assign gt_out_c = gt_in | (eq_in & a & ~b);
  assign eq_out_c = eq_in & ~(a ^ b);

endmodule

module mag_cmp_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
`ifdef MAG_CMP_SEQ_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_d, done_d, eq_d, lt_d, gt_d;

  logic             top_inv_c;
  logic [CHUNK-1:0] xa_c, yb_c;
  logic [CHUNK:0]   eq_chain, gt_chain;
  logic             slice_eq_c, slice_gt_c;

`ifdef MAG_CMP_SEQ_SIGNED_EN
  logic sgn_q, sgn_d;

  // Signed ordering only alters the sign bits of the top chunk.
  assign top_inv_c = sgn_q & (idx_q == IDX_TOP);
`else
  assign top_inv_c = 1'b0;
`endif

  // Current chunk: operands are shifted left so the active slice is always on top.
  always_comb begin
    xa_c = xs_q[WIDTH-1 -: CHUNK];
    yb_c = ys_q[WIDTH-1 -: CHUNK];
    if (top_inv_c) begin
      xa_c[CHUNK-1] = ~xa_c[CHUNK-1];
      yb_c[CHUNK-1] = ~yb_c[CHUNK-1];
    end
  end

  // Chain of 1-bit cells, seeded at the MSB end as "equal so far, not greater".
  assign eq_chain[CHUNK] = 1'b1;
  assign gt_chain[CHUNK] = 1'b0;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    mag_cmp_bit u_bit (
      .a        (xa_c[i]),
      .b        (yb_c[i]),
      .eq_in    (eq_chain[i+1]),
      .gt_in    (gt_chain[i+1]),
      .eq_out_c (eq_chain[i]),
      .gt_out_c (gt_chain[i])
    );
  end

  assign slice_eq_c = eq_chain[0];
  assign slice_gt_c = gt_chain[0];

  // State register and all registered outputs; reset discards any scan in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      gt      <= 1'b0;
`ifdef MAG_CMP_SEQ_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
      eq      <= eq_d;
      lt      <= lt_d;
      gt      <= gt_d;
`ifdef MAG_CMP_SEQ_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  // Next-state and next-output logic; results change only on a deciding SCAN cycle.
  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    idx_d   = idx_q;
    busy_d  = busy;
    done_d  = 1'b0;
    eq_d    = eq;
    lt_d    = lt;
    gt_d    = gt;
`ifdef MAG_CMP_SEQ_SIGNED_EN
    sgn_d   = sgn_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          xs_d    = x;
          ys_d    = y;
          idx_d   = IDX_TOP;
`ifdef MAG_CMP_SEQ_SIGNED_EN
          sgn_d   = sgn;
`endif
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (!slice_eq_c) begin
          eq_d    = 1'b0;
          gt_d    = slice_gt_c;
          lt_d    = ~slice_gt_c;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
          xs_d  = xs_q << CHUNK;
          ys_d  = ys_q << CHUNK;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Scoreboard bench for mag_cmp_seq (WIDTH=16, CHUNK=4): the driver pushes the
// expected result and latency on each accepted start; a monitor pops and
// compares whenever done is seen.
module tb_mag_cmp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] x, y;
  logic        busy, done, eq, lt, gt;
`ifdef MAG_CMP_SEQ_SIGNED_EN
  logic        sgn;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0] res;  // {eq, lt, gt}
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];

  mag_cmp_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
`ifdef MAG_CMP_SEQ_SIGNED_EN
    .sgn   (sgn),
`endif
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .lt    (lt),
    .gt    (gt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done eq/lt/gt=%b%b%b at cycle %0d, none expected", eq, lt, gt, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result_eq_lt_gt", 32'({eq, lt, gt}), 32'(e.res));
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy=%b done=%b required idle within 40 cycles", busy, done);
    end
  endtask

  // Issue one comparison and record its expectation; operands are scrambled afterwards.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sg,
                       input logic [2:0] res, input int k);
    exp_t e;
    wait_idle();
    x = a;
    y = b;
`ifdef MAG_CMP_SEQ_SIGNED_EN
    sgn = sg;
`else
    if (sg) $display("note: sgn ignored in unsigned build");
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    e.res = res;
    e.lat = k + 1;
    e.acc = cyc;
    q.push_back(e);
    start = 1'b0;
    x = ~a;
    y = ~b;
  endtask

  function automatic int exp_k(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 4; i++)
      if (a[15-4*i -: 4] != b[15-4*i -: 4]) return i + 1;
    return 4;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [15:0] a, b;
    int n;

    rst_n = 1'b0;
    start = 1'b0;
    x = '0;
    y = '0;
`ifdef MAG_CMP_SEQ_SIGNED_EN
    sgn = 1'b0;
`endif

    // Reset state after a clock edge under reset.
    #7;
    chk("reset_outputs", 32'({busy, done, eq, lt, gt}), 32'd0);

    // First start is accepted on the first edge after reset release.
    x = 16'h1234;
    y = 16'h1234;
    start = 1'b1;
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e.res = 3'b100;
    e.lat = 5;
    e.acc = cyc;
    q.push_back(e);
    start = 1'b0;
    x = 16'h0000;
    y = 16'hFFFF;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("no_result_yet", 32'({eq, lt, gt}), 32'd0);

    issue(16'h8000, 16'h7FFF, 1'b0, 3'b001, 1);
`ifdef MAG_CMP_SEQ_SIGNED_EN
    issue(16'h8000, 16'h7FFF, 1'b1, 3'b010, 1);
    issue(16'hFFFF, 16'h0001, 1'b1, 3'b010, 1);
    issue(16'h0001, 16'hFFFF, 1'b1, 3'b001, 1);
    issue(16'h1000, 16'h2000, 1'b1, 3'b010, 1);
    issue(16'hF0F0, 16'hF0F1, 1'b1, 3'b010, 4);
`endif
    issue(16'h00A5, 16'h00A6, 1'b0, 3'b010, 4);

    // Result holds while idle.
    wait_idle();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("hold_lt", 32'({eq, lt, gt}), 32'b010);

    // Start held high: no queuing during SCAN/DONE, re-accepted only in IDLE.
    x = 16'h1200;
    y = 16'h1300;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.res = 3'b010;
    e.lat = 3;
    e.acc = cyc;
    q.push_back(e);
    x = 16'h4000;
    y = 16'h3000;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    e.res = 3'b001;
    e.lat = 2;
    e.acc = cyc;
    q.push_back(e);
    start = 1'b0;
    chk("reaccept_busy", 32'(busy), 32'd1);

    issue(16'hFFFF, 16'hFFFE, 1'b0, 3'b001, 4);
    issue(16'h0F00, 16'h0E00, 1'b0, 3'b001, 2);
    issue(16'h00F0, 16'h0F00, 1'b0, 3'b010, 2);

    // Async reset during the second SCAN cycle; aborted comparison yields no done.
    wait_idle();
    x = 16'h0000;
    y = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({busy, done, eq, lt, gt}), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_idle", 32'({busy, done}), 32'd0);
    issue(16'h0001, 16'h0000, 1'b0, 3'b001, 4);

    // Model-checked operand pairs, biased toward long scans.
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (16'h0001 << $urandom_range(0, 15));
        default: b = 16'($urandom);
      endcase
      issue(a, b, 1'b0, {a == b, a < b, a > b}, exp_k(a, b));
    end

    // Drain outstanding expectations.
    wait_idle();
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
